// File: rtl/dcache_2way_wb.sv
// Two-way set-associative write-back, write-allocate data cache.
// LRU replacement, line-wide memory port, flush of all dirty lines.
module dcache_2way_wb #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256,
   parameter int SETS   = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic [ADDR_W-1:0] p1_addr_i,
   input  logic [31:0]       p1_data_i,
   input  logic              p1_MemRead_i,
   input  logic              p1_MemWrite_i,
   output logic [31:0]       p1_data_o,
   output logic              p1_stall_o,
   input  logic              flush_i,
   output logic              flush_busy_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [LINE_W-1:0] mem_data_o,
   input  logic [LINE_W-1:0] mem_data_i,
   output logic              mem_enable_o,
   output logic              mem_write_o,
   input  logic              mem_ack_i
);
   localparam int OFF_W = $clog2(LINE_W/8);
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
   localparam int WRD_W = OFF_W - 2;

   typedef enum logic [2:0] {
      S_IDLE, S_MISS, S_WB, S_REFILL, S_DONE, S_FSCAN, S_FWB
   } state_t;

   state_t r_state, w_next;

   logic [TAG_W-1:0]  r_tag   [2][SETS];
   logic [LINE_W-1:0] r_data  [2][SETS];
   logic [SETS-1:0]   r_valid [2];
   logic [SETS-1:0]   r_dirty [2];
   logic [SETS-1:0]   r_lru;
   logic              r_vway;
   logic              r_fway;
   logic [IDX_W-1:0]  r_fidx;
   logic              r_ack_q;

   logic [TAG_W-1:0]  w_tag;
   logic [IDX_W-1:0]  w_idx;
   logic [WRD_W-1:0]  w_wrd;
   logic              w_req, w_hit0, w_hit1, w_hit, w_hway;
   logic [LINE_W-1:0] w_hline;
   logic              w_acc, w_vict, w_fdirty, w_flast;
   logic              w_ack, w_vdirty;
   logic              w_unused;

   assign w_tag    = p1_addr_i[ADDR_W-1 -: TAG_W];
   assign w_idx    = p1_addr_i[OFF_W +: IDX_W];
   assign w_wrd    = p1_addr_i[2 +: WRD_W];
   assign w_unused = ^p1_addr_i[1:0];
   assign w_req    = p1_MemRead_i | p1_MemWrite_i;
   assign w_hit0   = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
   assign w_hit1   = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
   assign w_hit    = w_hit0 | w_hit1;
   assign w_hway   = w_hit1;
   assign w_hline  = r_data[w_hway][w_idx];
   assign w_acc    = (r_state == S_IDLE) && w_req && w_hit;
   assign w_vict   = !r_valid[0][w_idx] ? 1'b0 :
                     !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
   assign w_vdirty = r_valid[r_vway][w_idx] & r_dirty[r_vway][w_idx];
   assign w_fdirty = r_valid[r_fway][r_fidx] & r_dirty[r_fway][r_fidx];
   assign w_flast  = r_fway & (r_fidx == IDX_W'(SETS-1));
   assign w_ack    = mem_ack_i & ((r_state == S_WB) ||
                     (r_state == S_REFILL) || (r_state == S_FWB));

   assign p1_data_o    = (p1_MemRead_i && w_hit) ?
                         w_hline[w_wrd*32 +: 32] : 32'h0;
   assign p1_stall_o   = (r_state == S_IDLE) ? (w_req & ~w_hit) : 1'b1;
   assign flush_busy_o = (r_state == S_FSCAN) || (r_state == S_FWB);

   // State register; async reset aborts any miss or flush in progress
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next state and memory port; enable drops for one cycle after each ack
   always_comb begin
      w_next       = r_state;
      mem_enable_o = 1'b0;
      mem_write_o  = 1'b0;
      mem_addr_o   = '0;
      mem_data_o   = '0;
      unique case (r_state)
         S_IDLE: begin
            if (flush_i)              w_next = S_FSCAN;
            else if (w_req && !w_hit) w_next = S_MISS;
         end
         S_MISS: w_next = w_vdirty ? S_WB : S_REFILL;
         S_WB: begin
            mem_enable_o = ~r_ack_q;
            mem_write_o  = 1'b1;
            mem_addr_o   = {r_tag[r_vway][w_idx], w_idx, {OFF_W{1'b0}}};
            mem_data_o   = r_data[r_vway][w_idx];
            if (w_ack) w_next = S_REFILL;
         end
         S_REFILL: begin
            mem_enable_o = ~r_ack_q;
            mem_addr_o   = {w_tag, w_idx, {OFF_W{1'b0}}};
            if (w_ack) w_next = S_DONE;
         end
         S_DONE: w_next = S_IDLE;
         S_FSCAN: begin
            if (w_fdirty)     w_next = S_FWB;
            else if (w_flast) w_next = S_IDLE;
         end
         S_FWB: begin
            mem_enable_o = ~r_ack_q;
            mem_write_o  = 1'b1;
            mem_addr_o   = {r_tag[r_fway][r_fidx], r_fidx, {OFF_W{1'b0}}};
            mem_data_o   = r_data[r_fway][r_fidx];
            if (w_ack) w_next = w_flast ? S_IDLE : S_FSCAN;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Valid/dirty/LRU bookkeeping, victim latch and flush scan counter
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_valid[0] <= '0;
         r_valid[1] <= '0;
         r_dirty[0] <= '0;
         r_dirty[1] <= '0;
         r_lru      <= '0;
         r_vway     <= 1'b0;
         r_fway     <= 1'b0;
         r_fidx     <= '0;
         r_ack_q    <= 1'b0;
      end else begin
         r_ack_q <= w_ack;
         if (w_acc) begin
            r_lru[w_idx] <= ~w_hway;
            if (p1_MemWrite_i) r_dirty[w_hway][w_idx] <= 1'b1;
         end
         if ((r_state == S_IDLE) && !flush_i && w_req && !w_hit)
            r_vway <= w_vict;
         if ((r_state == S_IDLE) && flush_i) begin
            r_fidx <= '0;
            r_fway <= 1'b0;
         end
         if ((r_state == S_REFILL) && w_ack) begin
            r_valid[r_vway][w_idx] <= 1'b1;
            r_dirty[r_vway][w_idx] <= 1'b0;
         end
         if ((r_state == S_FWB) && w_ack)
            r_dirty[r_fway][r_fidx] <= 1'b0;
         if ((((r_state == S_FSCAN) && !w_fdirty) ||
              ((r_state == S_FWB) && w_ack)) && !w_flast)
            {r_fidx, r_fway} <= {r_fidx, r_fway} + 1'b1;
      end
   end

   // Tag and line storage: store-hit word merge and refill write
   always_ff @(posedge clk_i) begin
      if (w_acc && p1_MemWrite_i)
         r_data[w_hway][w_idx][w_wrd*32 +: 32] <= p1_data_i;
      if ((r_state == S_REFILL) && w_ack) begin
         r_data[r_vway][w_idx] <= mem_data_i;
         r_tag[r_vway][w_idx]  <= w_tag;
      end
   end

endmodule
